// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory port arbiter: port op encoding
// and default geometry.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    localparam int WIDTH1_DEF   = 32;
    localparam int MEM_SIZE_DEF = 1024;
    localparam int LOAD_CNT_W   = 16;

endpackage

// File: rtl/imem_arb_prio.sv
// Grant decision between loader and fetch, with a bounded run of consecutive
// load grants while a fetch is kept waiting.
module imem_arb_prio #(
    parameter int MAX_LOAD_RUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_valid,
    input  logic fetch_req_valid,
    input  logic fetch_ok,
    output logic grant_load,
    output logic grant_fetch
);

    localparam int               RUN_W   = $clog2(MAX_LOAD_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LOAD_RUN);

    logic [RUN_W-1:0] load_run;

    always_comb begin
        grant_fetch = 1'b0;
        grant_load  = 1'b0;
        if (!reset) begin
            if (fetch_req_valid && fetch_ok && (!load_valid || load_run == RUN_MAX)) begin
                grant_fetch = 1'b1;
            end else begin
                grant_load = load_valid;
            end
        end
    end

    // Saturate at the limit so a fetch that only becomes eligible later still wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_run <= '0;
        end else if (grant_fetch || !fetch_req_valid) begin
            load_run <= '0;
        end else if (grant_load && load_run != RUN_MAX) begin
            load_run <= load_run + RUN_W'(1);
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory front end: arbitrates fetch reads and loader
// writes, registers every memory-port output and range-checks both requesters.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int WIDTH1       = WIDTH1_DEF,
    parameter int MEM_SIZE     = MEM_SIZE_DEF,
    parameter int MAX_LOAD_RUN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req_valid,
    output logic                  fetch_req_ready,
    input  logic [WIDTH1-1:0]     fetch_addr,
    output logic                  fetch_rsp_valid,
    input  logic                  fetch_rsp_ready,
    output logic [WIDTH1-1:0]     fetch_rsp_data,
    output logic                  fetch_rsp_err,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH1-1:0]     load_addr,
    input  logic [WIDTH1-1:0]     load_data,
    output logic                  load_err,
    output logic [LOAD_CNT_W-1:0] load_count,
    output logic [WIDTH1-1:0]     mem_addr,
    output logic                  mem_wr,
    output logic [WIDTH1-1:0]     mem_wdata,
    input  logic [WIDTH1-1:0]     mem_rdata
);

    localparam logic [WIDTH1-1:0] MEM_LIM = WIDTH1'(MEM_SIZE);

    function automatic logic [LOAD_CNT_W-1:0] sat_inc(input logic [LOAD_CNT_W-1:0] v);
        return (&v) ? v : v + LOAD_CNT_W'(1);
    endfunction

    op_t               op_q;
    logic              outstanding;
    logic              rd_vld_p1;
    logic              rd_err_p1;
    logic              fetch_ok;
    logic              grant_load;
    logic              grant_fetch;
    logic              fetch_bad;
    logic              load_bad;
    logic [WIDTH1-1:0] fetch_word;

    assign fetch_word = fetch_addr >> 2;
    assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_word >= MEM_LIM);
    assign load_bad   = (load_addr >= MEM_LIM);
    // The response handshake frees the slot in the same cycle it completes.
    assign fetch_ok   = !outstanding || (fetch_rsp_valid && fetch_rsp_ready);

    imem_arb_prio #(
        .MAX_LOAD_RUN(MAX_LOAD_RUN)
    ) u_prio (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .fetch_req_valid(fetch_req_valid),
        .fetch_ok       (fetch_ok),
        .grant_load     (grant_load),
        .grant_fetch    (grant_fetch)
    );

    assign fetch_req_ready = grant_fetch;
    assign load_ready      = grant_load;

    // Stage p0 -> p1: acceptance loads the memory port register.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_NONE;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_vld_p1  <= 1'b0;
            rd_err_p1  <= 1'b0;
            load_err   <= 1'b0;
            load_count <= '0;
        end else begin
            op_q      <= OP_NONE;
            mem_wr    <= 1'b0;
            rd_vld_p1 <= grant_fetch;
            rd_err_p1 <= grant_fetch && fetch_bad;
            load_err  <= grant_load && load_bad;
            if (grant_fetch && !fetch_bad) begin
                op_q     <= OP_READ;
                mem_addr <= fetch_word;
            end
            if (grant_load && !load_bad) begin
                op_q       <= OP_WRITE;
                mem_wr     <= 1'b1;
                mem_addr   <= load_addr;
                mem_wdata  <= load_data;
                load_count <= sat_inc(load_count);
            end
        end
    end

    // Stage p1 -> p2: capture read data into the held response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_rsp_valid <= 1'b0;
            fetch_rsp_data  <= '0;
            fetch_rsp_err   <= 1'b0;
            outstanding     <= 1'b0;
        end else begin
            if (rd_vld_p1) begin
                fetch_rsp_valid <= 1'b1;
                fetch_rsp_data  <= (op_q == OP_READ) ? mem_rdata : '0;
                fetch_rsp_err   <= rd_err_p1;
            end else if (fetch_rsp_valid && fetch_rsp_ready) begin
                fetch_rsp_valid <= 1'b0;
            end
            if (grant_fetch) begin
                outstanding <= 1'b1;
            end else if (fetch_rsp_valid && fetch_rsp_ready) begin
                outstanding <= 1'b0;
            end
        end
    end

endmodule
